// File: rtl/present_pkg.sv
// Shared PRESENT constants, helper functions and the FSM state type.
package present_pkg;

  localparam int BLOCK_W   = 64;
  localparam int KEY_W_80  = 80;
  localparam int KEY_W_128 = 128;

  // S-box table packed by input value: entry x occupies bits [4x+3:4x].
  // Values for x = 0..15 are C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int n = 0; n < BLOCK_W / 4; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit i moves to (16*i) mod 63; the top bit is a fixed point.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_W - 1; i++) begin
      y[(16 * i) % 63] = x[i];
    end
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

endpackage

// File: rtl/present_encrypt_core_key_update.sv
// Combinational PRESENT key-schedule step for 80- or 128-bit keys.
module present_key_update
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80
) (
  input  logic [KEY_WIDTH-1:0] key_reg,
  input  logic [4:0]           round_index,
  output logic [KEY_WIDTH-1:0] key_next
);

  logic [KEY_WIDTH-1:0] rot;

  // Rotate left by 61 positions.
  assign rot = {key_reg[KEY_WIDTH-62:0], key_reg[KEY_WIDTH-1:KEY_WIDTH-61]};

  generate
    if (KEY_WIDTH == KEY_W_128) begin : g_k128
      // Two top nibbles through the S-box, counter folded into [66:62].
      always_comb begin
        key_next          = rot;
        key_next[127:124] = sbox4(rot[127:124]);
        key_next[123:120] = sbox4(rot[123:120]);
        key_next[66:62]   = rot[66:62] ^ round_index;
      end
    end else begin : g_k80
      // Top nibble through the S-box, counter folded into [19:15].
      always_comb begin
        key_next        = rot;
        key_next[79:76] = sbox4(rot[79:76]);
        key_next[19:15] = rot[19:15] ^ round_index;
      end
    end
  endgenerate

endmodule

// File: rtl/present_encrypt_core.sv
// Iterative PRESENT encryption core: one S/P round per clock, key schedule
// computed on the fly, valid/ready handshakes on input and output.
module present_encrypt_core
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [KEY_WIDTH-1:0] in_key,
  input  logic [BLOCK_W-1:0]   in_plaintext,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLOCK_W-1:0]   out_ciphertext,
  output logic                 busy,
  output logic [4:0]           round_index
);

  generate
    if (KEY_WIDTH != KEY_W_80 && KEY_WIDTH != KEY_W_128) begin : g_bad_key
      $error("present_encrypt_core: KEY_WIDTH must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present_encrypt_core: ROUNDS must be in 1..31");
    end
  endgenerate

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  state_e                 fsm_q, fsm_d;
  logic [BLOCK_W-1:0]     data_q, data_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [KEY_WIDTH-1:0]   key_next;
  logic [4:0]             round_q, round_d;
  logic [BLOCK_W-1:0]     ct_q, ct_d;
  logic                   valid_q, valid_d;
  logic [BLOCK_W-1:0]     round_key;
  logic                   accept;

  assign round_key = key_q[KEY_WIDTH-1 -: BLOCK_W];
  assign accept    = (fsm_q == IDLE) && in_valid && !clear;

  present_key_update #(.KEY_WIDTH(KEY_WIDTH)) u_key_update (
    .key_reg     (key_q),
    .round_index (round_q),
    .key_next    (key_next)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = RUN;
      RUN:     if (round_q == LAST_ROUND) fsm_d = FIN;
      FIN:     fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    if (clear) fsm_d = IDLE;
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    in_ready = (fsm_q == IDLE);
    busy     = (fsm_q == RUN);
  end

  // Datapath next values: load, round, whitening, and output release.
  always_comb begin
    data_d  = data_q;
    key_d   = key_q;
    round_d = round_q;
    ct_d    = ct_q;
    valid_d = valid_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_plaintext;
          key_d   = in_key;
          round_d = 5'd1;
        end
      end
      RUN: begin
        data_d = p_layer(sbox_layer(data_q ^ round_key));
        key_d  = key_next;
        // Hold at the last round so the 5-bit counter never wraps.
        if (round_q != LAST_ROUND) round_d = round_q + 5'd1;
      end
      FIN: begin
        ct_d    = data_q ^ round_key;
        valid_d = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          round_d = 5'd0;
        end
      end
      default: ;
    endcase
    // Abort drops control state only; data registers keep their contents.
    if (clear) begin
      valid_d = 1'b0;
      round_d = 5'd0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      key_q   <= '0;
      round_q <= '0;
      ct_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      key_q   <= key_d;
      round_q <= round_d;
      ct_q    <= ct_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_ciphertext = ct_q;
  assign round_index    = round_q;

endmodule

// File: tb/tb_present_encrypt_core.sv
// Bench for present_encrypt_core: an 80-bit and a 128-bit instance share
// all stimulus and are checked against tabled vectors and a reference model.
module tb_present_encrypt_core;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_key = '0;
  logic [63:0]  in_plaintext = '0;

  logic         in_ready_a, out_valid_a, busy_a;
  logic [63:0]  ct_a;
  logic [4:0]   ri_a;
  logic         in_ready_b, out_valid_b, busy_b;
  logic [63:0]  ct_b;
  logic [4:0]   ri_b;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clock = ~clock;

  present_encrypt_core #(.KEY_WIDTH(80), .ROUNDS(31)) dut_a (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_key(in_key[79:0]), .in_plaintext(in_plaintext),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_ciphertext(ct_a), .busy(busy_a), .round_index(ri_a)
  );

  present_encrypt_core #(.KEY_WIDTH(128), .ROUNDS(31)) dut_b (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_key(in_key), .in_plaintext(in_plaintext),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ciphertext(ct_b), .busy(busy_b), .round_index(ri_b)
  );

  typedef struct {
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  exp;
    bit           w128;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference PRESENT encryption from the cipher definition, bit by bit.
  function automatic logic [63:0] ref_enc(input logic [127:0] key, input logic [63:0] pt,
                                          input int kw);
    logic [127:0] k, nk;
    logic [63:0]  s, t, rk;
    logic [4:0]   rc;
    int           lo;
    k = '0;
    for (int i = 0; i < kw; i++) k[i] = key[i];
    s = pt;
    lo = (kw == 80) ? 15 : 62;
    for (int r = 1; r <= 31; r++) begin
      for (int j = 0; j < 64; j++) rk[j] = k[kw-64+j];
      s = s ^ rk;
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
      s = t;
      nk = '0;
      for (int i = 0; i < kw; i++) nk[(i + 61) % kw] = k[i];
      k = nk;
      k[kw-4 +: 4] = sb[k[kw-4 +: 4]];
      if (kw == 128) k[kw-8 +: 4] = sb[k[kw-8 +: 4]];
      rc = 5'(r);
      k[lo +: 5] = k[lo +: 5] ^ rc;
    end
    for (int j = 0; j < 64; j++) rk[j] = k[kw-64+j];
    return s ^ rk;
  endfunction

  // Offer one block, then wait (bounded) for out_valid; checks latency and in_ready.
  task automatic do_op(input logic [127:0] key, input logic [63:0] pt,
                       output logic [63:0] ca, output logic [63:0] cb);
    int lat;
    bit ready_low;
    @(negedge clock);
    in_key = key; in_plaintext = pt; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    in_key = {$urandom, $urandom, $urandom, $urandom};
    in_plaintext = {$urandom, $urandom};
    lat = 0; ready_low = 1'b1;
    while (!out_valid_a && lat < 100) begin
      if (in_ready_a) ready_low = 1'b0;
      @(posedge clock); lat++;
      @(negedge clock);
    end
    chk("latency", 64'(lat), 64'd32);
    chk("in_ready_low_while_busy", {63'd0, ready_low}, 64'd1);
    chk("out_valid_128_aligned", {63'd0, out_valid_b}, 64'd1);
    ca = ct_a; cb = ct_b;
  endtask

  task automatic handshake();
    @(negedge clock); out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock); out_ready = 1'b0;
    chk("out_valid_after_ack", {63'd0, out_valid_a}, 64'd0);
    chk("in_ready_after_ack", {63'd0, in_ready_a}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ca, cb, held;
    logic [127:0] k;
    logic [63:0] p;
    int n;
    bit ok;

    tbl[0] = '{128'd0, 64'd0, 64'h5579C1387B228445, 1'b0};
    tbl[1] = '{{48'd0, {80{1'b1}}}, {64{1'b1}}, 64'h3333DCD3213210D2, 1'b0};
    tbl[2] = '{128'd0, {64{1'b1}}, 64'hA112FFC72F68417B, 1'b0};
    tbl[3] = '{128'd0, 64'd0, 64'h96DB702A2E6900AF, 1'b1};

    // Reset state.
    repeat (3) @(negedge clock);
    chk("reset_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid_a}, 64'd0);
    chk("reset_ct", ct_a, 64'd0);
    chk("reset_busy_round", {58'd0, busy_a, ri_a}, 64'd0);
    reset_n = 1'b1;

    // Tabled known-answer vectors; the other width is checked against the model.
    for (int i = 0; i < 4; i++) begin
      do_op(tbl[i].key, tbl[i].pt, ca, cb);
      if (tbl[i].w128) begin
        chk($sformatf("kat%0d_128", i), cb, tbl[i].exp);
        chk($sformatf("kat%0d_80_model", i), ca, ref_enc(tbl[i].key, tbl[i].pt, 80));
      end else begin
        chk($sformatf("kat%0d_80", i), ca, tbl[i].exp);
        chk($sformatf("kat%0d_128_model", i), cb, ref_enc(tbl[i].key, tbl[i].pt, 128));
      end
      handshake();
    end

    // Back-to-back: second pair held on in_valid while the first runs.
    @(negedge clock);
    in_key = {48'd0, {80{1'b1}}}; in_plaintext = {64{1'b1}}; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_key = 128'd0;
    ok = 1'b1; n = 0;
    while (!out_valid_a && n < 100) begin
      if (in_ready_a) ok = 1'b0;
      @(posedge clock); n++;
      @(negedge clock);
    end
    if (in_ready_a) ok = 1'b0;
    chk("b2b_first_latency", 64'(n), 64'd32);
    chk("b2b_first_ct", ct_a, 64'h3333DCD3213210D2);
    chk("b2b_in_ready_low", {63'd0, ok}, 64'd1);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    chk("b2b_idle_after_ack", {63'd0, in_ready_a}, 64'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid_a && n < 100) begin
      @(posedge clock); n++;
      @(negedge clock);
    end
    chk("b2b_second_latency", 64'(n), 64'd32);
    chk("b2b_second_ct", ct_a, 64'hA112FFC72F68417B);
    handshake();

    // Backpressure: output held for 10 cycles while in_valid pulses are ignored.
    k = {$urandom, $urandom, $urandom, $urandom}; p = {$urandom, $urandom};
    do_op(k, p, ca, cb);
    chk("bp_ct_model", ca, ref_enc(k, p, 80));
    held = ct_a; ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2 == 0);
      in_key = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clock);
      @(negedge clock);
      if (!out_valid_a || ct_a !== held || in_ready_a) ok = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_held_stable", {63'd0, ok}, 64'd1);
    handshake();
    chk("bp_ct_kept_after_ack", ct_a, held);

    // Abort at round 7.
    @(negedge clock);
    in_key = '0; in_plaintext = '0; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; n = 0;
    while (ri_a != 5'd7 && n < 40) begin
      @(posedge clock); n++;
      @(negedge clock);
    end
    chk("abort_reached_round7", {59'd0, ri_a}, 64'd7);
    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    chk("abort_out_valid", {63'd0, out_valid_a}, 64'd0);
    chk("abort_busy", {63'd0, busy_a}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("abort_round_index", {59'd0, ri_a}, 64'd0);
    clear = 1'b1; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_blocks_accept", {62'd0, busy_a, in_ready_a}, 64'd1);
    do_op(128'd0, 64'd0, ca, cb);
    chk("after_abort_ct", ca, 64'h5579C1387B228445);
    handshake();

    // Asynchronous reset mid-RUN.
    do_op(128'd0, 64'd0, ca, cb);
    handshake();
    @(negedge clock);
    in_key = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("areset_out_valid", {62'd0, out_valid_a, out_valid_b}, 64'd0);
    chk("areset_ct", ct_a | ct_b, 64'd0);
    chk("areset_busy_round", {58'd0, busy_a, ri_a}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (out_valid_a || out_valid_b) ok = 1'b0;
    end
    chk("no_valid_after_reset", {63'd0, ok}, 64'd1);

    // Randomized blocks against the reference model.
    for (int r = 0; r < 16; r++) begin
      k = {$urandom, $urandom, $urandom, $urandom}; p = {$urandom, $urandom};
      do_op(k, p, ca, cb);
      chk($sformatf("rand%0d_80", r), ca, ref_enc(k, p, 80));
      chk($sformatf("rand%0d_128", r), cb, ref_enc(k, p, 128));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      handshake();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
